// File: rtl/multi_alarm_clock_if.sv
// Front-panel / display bundle for multi_alarm_clock.
//   slave  : the clock itself (consumes digits, buttons, enables; drives
//            the BCD display, buzzer, ringing slot id, tick and load error)
//   master : whatever drives the front panel and watches the outputs
interface multi_alarm_clock_if #(
   parameter int N_ALARMS = 4
);
   localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

   logic [1:0]          H_in1;
   logic [3:0]          H_in0;
   logic [3:0]          M_in1;
   logic [3:0]          M_in0;
   logic                LD_time;
   logic                LD_alarm;
   logic [AW-1:0]       al_sel;
   logic [N_ALARMS-1:0] AL_ON;
   logic                STOP_al;
   logic                SNOOZE;

   logic [1:0]          H_out1;
   logic [3:0]          H_out0;
   logic [3:0]          M_out1;
   logic [3:0]          M_out0;
   logic [3:0]          S_out1;
   logic [3:0]          S_out0;
   logic                Alarm;
   logic [AW-1:0]       alarm_id;
   logic                tick;
   logic                ld_err;

   modport slave (
      input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, al_sel, AL_ON,
             STOP_al, SNOOZE,
      output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm, alarm_id,
             tick, ld_err
   );

   modport master (
      output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, al_sel, AL_ON,
             STOP_al, SNOOZE,
      input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, Alarm, alarm_id,
             tick, ld_err
   );
endinterface

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD time-of-day clock with N_ALARMS programmable alarms, snooze,
// ring auto-timeout and rejection of invalid HH:MM loads.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : multi_alarm_clock_if.slave (digits, load strobes, slot select,
//           enables, stop/snooze buttons; BCD time, Alarm, alarm_id, tick,
//           ld_err -- all outputs registered)
//
// Alarm FSM
//   state     | meaning
//   S_IDLE    | quiet, waiting for an enabled slot to match on a minute edge
//   S_RINGING | Alarm high, counting ticks toward RING_MAX_S
//   S_SNOOZED | Alarm low, waiting for the snooze target minute
module multi_alarm_clock #(
   parameter int CLK_DIV    = 10,
   parameter int N_ALARMS   = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MAX_S = 60
) (
   input logic               clk,
   input logic               reset,
   multi_alarm_clock_if.slave bus
);
   localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam int RW = (RING_MAX_S > 1) ? $clog2(RING_MAX_S) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_MAX_S - 1);
   localparam logic [3:0]    SNZ_M1    = 4'(SNOOZE_MIN / 10);
   localparam logic [3:0]    SNZ_M0    = 4'(SNOOZE_MIN % 10);

   typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZED} state_t;
   typedef struct packed {
      logic [1:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
   } hhmm_t;

   state_t        state_q, state_d;
   hhmm_t         hm_q, hm_d, nxt_hm, in_hm, snz_q, snz_d, snz_tgt;
   hhmm_t         al_q [N_ALARMS];
   hhmm_t         al_d [N_ALARMS];
   logic [3:0]    s1_q, s1_d, s0_q, s0_d, nxt_s1, nxt_s0;
   logic [DW-1:0] div_q, div_d;
   logic [RW-1:0] ring_q, ring_d;
   logic [AW-1:0] alarm_id_q, alarm_id_d, match_id;
   logic          tick_q, tick_d, alarm_q, alarm_d, ld_err_q, ld_err_d;
   logic          tick_now, tick_eff, min_edge, in_ok, sel_ok;
   logic          time_load, al_load, match_hit;
   logic [4:0]    sm0_sum, sm1_sum;
   logic          c0, c1;

   function automatic logic [5:0] hour_inc(input logic [1:0] h1, input logic [3:0] h0);
      if (h1 == 2'd2 && h0 == 4'd3) return 6'd0;
      else if (h0 == 4'd9)          return {h1 + 2'd1, 4'd0};
      else                          return {h1, h0 + 4'd1};
   endfunction

   assign in_hm = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
   assign in_ok = ((bus.H_in1 < 2'd2 && bus.H_in0 <= 4'd9) ||
                   (bus.H_in1 == 2'd2 && bus.H_in0 <= 4'd3)) &&
                  bus.M_in1 <= 4'd5 && bus.M_in0 <= 4'd9;

   // Only non-power-of-two slot counts can see an out-of-range select.
   if (N_ALARMS < (1 << AW)) begin : g_sel_chk
      assign sel_ok = (bus.al_sel < AW'(N_ALARMS));
   end else begin : g_sel_all
      assign sel_ok = 1'b1;
   end

   assign time_load = bus.LD_time && in_ok;
   assign al_load   = bus.LD_alarm && in_ok && sel_ok;
   assign ld_err_d  = (bus.LD_time && !in_ok) || (bus.LD_alarm && !(in_ok && sel_ok));

   assign tick_now = (div_q == DIV_LAST);
   assign tick_eff = tick_now && !time_load;
   assign div_d    = (time_load || tick_now) ? '0 : div_q + 1'b1;
   assign tick_d   = (div_d == DIV_LAST);

   // BCD increment of the running time; min_edge marks "next seconds are 00".
   assign min_edge = (s1_q == 4'd5) && (s0_q == 4'd9);
   always_comb begin
      nxt_hm = hm_q;
      nxt_s1 = s1_q;
      nxt_s0 = s0_q + 4'd1;
      if (s0_q == 4'd9) begin
         nxt_s0 = 4'd0;
         nxt_s1 = s1_q + 4'd1;
         if (s1_q == 4'd5) begin
            nxt_s1    = 4'd0;
            nxt_hm.m0 = hm_q.m0 + 4'd1;
            if (hm_q.m0 == 4'd9) begin
               nxt_hm.m0 = 4'd0;
               nxt_hm.m1 = hm_q.m1 + 4'd1;
               if (hm_q.m1 == 4'd5) begin
                  nxt_hm.m1 = 4'd0;
                  {nxt_hm.h1, nxt_hm.h0} = hour_inc(hm_q.h1, hm_q.h0);
               end
            end
         end
      end
   end

   always_comb begin
      hm_d = hm_q;
      s1_d = s1_q;
      s0_d = s0_q;
      if (time_load) begin
         hm_d = in_hm;
         s1_d = 4'd0;
         s0_d = 4'd0;
      end else if (tick_now) begin
         hm_d = nxt_hm;
         s1_d = nxt_s1;
         s0_d = nxt_s0;
      end
      for (int i = 0; i < N_ALARMS; i++) begin
         al_d[i] = al_q[i];
         if (al_load && int'(bus.al_sel) == i) al_d[i] = in_hm;
      end
   end

   // Scan high to low so the lowest matching enabled slot wins.
   always_comb begin
      match_hit = 1'b0;
      match_id  = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (bus.AL_ON[i] && al_q[i] == nxt_hm) begin
            match_hit = 1'b1;
            match_id  = AW'(i);
         end
      end
   end

   // Snooze target = current HH:MM + SNOOZE_MIN, digit-wise with 24 h wrap.
   always_comb begin
      snz_tgt = hm_q;
      sm0_sum = {1'b0, hm_q.m0} + {1'b0, SNZ_M0};
      c0      = (sm0_sum >= 5'd10);
      snz_tgt.m0 = c0 ? 4'(sm0_sum - 5'd10) : sm0_sum[3:0];
      sm1_sum = {1'b0, hm_q.m1} + {1'b0, SNZ_M1} + {4'd0, c0};
      c1      = (sm1_sum >= 5'd6);
      snz_tgt.m1 = c1 ? 4'(sm1_sum - 5'd6) : sm1_sum[3:0];
      if (c1) {snz_tgt.h1, snz_tgt.h0} = hour_inc(hm_q.h1, hm_q.h0);
   end

   always_comb begin
      state_d    = state_q;
      alarm_id_d = alarm_id_q;
      ring_d     = ring_q;
      snz_d      = snz_q;
      if (time_load) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tick_eff && min_edge && match_hit) begin
                  state_d    = S_RINGING;
                  alarm_id_d = match_id;
                  ring_d     = '0;
               end
            end
            S_RINGING: begin
               if (!bus.AL_ON[alarm_id_q] || bus.STOP_al) begin
                  state_d = S_IDLE;
               end else if (bus.SNOOZE) begin
                  state_d = S_SNOOZED;
                  snz_d   = snz_tgt;
               end else if (tick_eff) begin
                  if (ring_q == RING_LAST) state_d = S_IDLE;
                  else                     ring_d  = ring_q + 1'b1;
               end
            end
            S_SNOOZED: begin
               if (!bus.AL_ON[alarm_id_q] || bus.STOP_al) begin
                  state_d = S_IDLE;
               end else if (tick_eff && min_edge && nxt_hm == snz_q) begin
                  state_d = S_RINGING;
                  ring_d  = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign alarm_d = (state_d == S_RINGING);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         hm_q       <= '0;
         s1_q       <= '0;
         s0_q       <= '0;
         al_q       <= '{default: '0};
         snz_q      <= '0;
         div_q      <= '0;
         ring_q     <= '0;
         alarm_id_q <= '0;
         tick_q     <= 1'b0;
         alarm_q    <= 1'b0;
         ld_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hm_q       <= hm_d;
         s1_q       <= s1_d;
         s0_q       <= s0_d;
         al_q       <= al_d;
         snz_q      <= snz_d;
         div_q      <= div_d;
         ring_q     <= ring_d;
         alarm_id_q <= alarm_id_d;
         tick_q     <= tick_d;
         alarm_q    <= alarm_d;
         ld_err_q   <= ld_err_d;
      end
   end

   assign bus.H_out1   = hm_q.h1;
   assign bus.H_out0   = hm_q.h0;
   assign bus.M_out1   = hm_q.m1;
   assign bus.M_out0   = hm_q.m0;
   assign bus.S_out1   = s1_q;
   assign bus.S_out0   = s0_q;
   assign bus.Alarm    = alarm_q;
   assign bus.alarm_id = alarm_id_q;
   assign bus.tick     = tick_q;
   assign bus.ld_err   = ld_err_q;
endmodule
